// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order committed-store FIFO feeding the D-cache write port
//
// Purpose: holds committed stores until the D-cache accepts them, retires them
// strictly in order, flags loads that must stall behind pending stores and
// reports fence drain status and write bus errors.
//
// Ports:
//   clk, reset, phi2                  clock, async active-high reset, clock enable
//   enq, enqpa, enqdata, enqsz,
//   enqcache, full                    store commit side
//   ldpa, ldsz, ldreq, ldcache,
//   conflict                          load hazard check
//   fence, fencebusy                  drain request / status
//   dcwrite, dcpa, dcwdata, dcsz,
//   dccache, dcbusy, dcdbe, wberr     D-cache write side
//   count                             number of valid entries
module store_queue #(
  parameter int DEPTH = 4,
  parameter int PAW   = 32,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     phi2,
  input  logic                     enq,
  input  logic [PAW-1:0]           enqpa,
  input  logic [DW-1:0]            enqdata,
  input  logic [2:0]               enqsz,
  input  logic                     enqcache,
  output logic                     full,
  input  logic [PAW-1:0]           ldpa,
  input  logic [2:0]               ldsz,
  input  logic                     ldreq,
  input  logic                     ldcache,
  output logic                     conflict,
  input  logic                     fence,
  output logic                     fencebusy,
  output logic                     dcwrite,
  output logic [PAW-1:0]           dcpa,
  output logic [DW-1:0]            dcwdata,
  output logic [2:0]               dcsz,
  output logic                     dccache,
  input  logic                     dcbusy,
  input  logic                     dcdbe,
  output logic                     wberr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  // Entry payload: no reset needed, qualified by r_valid.
  logic [PAW-1:0] r_pa    [DEPTH];
  logic [DW-1:0]  r_data  [DEPTH];
  logic [2:0]     r_sz    [DEPTH];
  logic           r_cache [DEPTH];

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic             r_wberr;

  logic w_full;
  logic w_enq;
  logic w_retire;
  logic w_conflict;

  // Byte lanes [a0, a0+asz] and [b0, b0+bsz] intersect; ends are 4 bits so a
  // range running past lane 7 never wraps back onto low lanes.
  function automatic logic f_overlap(input logic [2:0] a0, input logic [2:0] asz,
                                     input logic [2:0] b0, input logic [2:0] bsz);
    logic [3:0] a_end;
    logic [3:0] b_end;
    a_end = {1'b0, a0} + {1'b0, asz};
    b_end = {1'b0, b0} + {1'b0, bsz};
    return ({1'b0, a0} <= b_end) && ({1'b0, b0} <= a_end);
  endfunction

  // full comes from registered count only, so a retire in the same cycle
  // does not open a slot for the enqueue.
  assign w_full   = (r_count == DEPTH_C);
  assign w_enq    = enq & ~w_full;
  assign w_retire = r_valid[r_head] & ~dcbusy;

  assign full      = w_full;
  assign count     = r_count;
  assign wberr     = r_wberr;
  assign dcwrite   = r_valid[r_head];
  assign dcpa      = r_pa[r_head];
  assign dcwdata   = r_data[r_head];
  assign dcsz      = r_sz[r_head];
  assign dccache   = r_cache[r_head];
  assign fencebusy = fence & ((r_count != '0) | enq);
  assign conflict  = w_conflict;

  always_comb begin
    w_conflict = 1'b0;
    if (ldreq) begin
      // Uncached loads must wait for every older store to drain.
      if (!ldcache && ((r_count != '0) || enq)) begin
        w_conflict = 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && (r_pa[i][PAW-1:3] == ldpa[PAW-1:3]) &&
            f_overlap(r_pa[i][2:0], r_sz[i], ldpa[2:0], ldsz)) begin
          w_conflict = 1'b1;
        end
      end
      if (w_enq && (enqpa[PAW-1:3] == ldpa[PAW-1:3]) &&
          f_overlap(enqpa[2:0], enqsz, ldpa[2:0], ldsz)) begin
        w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_wberr <= 1'b0;
    end else if (phi2) begin
      // Enqueue and retire never hit the same slot: retire needs a valid head,
      // enqueue needs a non-full queue, so head==tail implies an empty queue.
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_enq, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wberr <= w_retire & dcdbe;
    end
  end

  always_ff @(posedge clk) begin
    if (phi2 && w_enq) begin
      r_pa[r_tail]    <= enqpa;
      r_data[r_tail]  <= enqdata;
      r_sz[r_tail]    <= enqsz;
      r_cache[r_tail] <= enqcache;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed self-checking bench for store_queue
module tb_store_queue;

  logic        clk;
  logic        reset;
  logic        phi2;
  logic        enq;
  logic [31:0] enqpa;
  logic [63:0] enqdata;
  logic [2:0]  enqsz;
  logic        enqcache;
  logic        full;
  logic [31:0] ldpa;
  logic [2:0]  ldsz;
  logic        ldreq;
  logic        ldcache;
  logic        conflict;
  logic        fence;
  logic        fencebusy;
  logic        dcwrite;
  logic [31:0] dcpa;
  logic [63:0] dcwdata;
  logic [2:0]  dcsz;
  logic        dccache;
  logic        dcbusy;
  logic        dcdbe;
  logic        wberr;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  store_queue #(.DEPTH(4), .PAW(32), .DW(64)) dut (
    .clk(clk), .reset(reset), .phi2(phi2),
    .enq(enq), .enqpa(enqpa), .enqdata(enqdata), .enqsz(enqsz), .enqcache(enqcache),
    .full(full),
    .ldpa(ldpa), .ldsz(ldsz), .ldreq(ldreq), .ldcache(ldcache), .conflict(conflict),
    .fence(fence), .fencebusy(fencebusy),
    .dcwrite(dcwrite), .dcpa(dcpa), .dcwdata(dcwdata), .dcsz(dcsz), .dccache(dccache),
    .dcbusy(dcbusy), .dcdbe(dcdbe), .wberr(wberr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic e, input logic [31:0] pa, input logic [2:0] sz,
                         input logic [63:0] d);
    enq     = e;
    enqpa   = pa;
    enqsz   = sz;
    enqdata = d;
  endtask

  initial begin
    reset = 1'b1; phi2 = 1'b1; enq = 1'b0; enqpa = '0; enqdata = '0; enqsz = '0;
    enqcache = 1'b1; ldpa = '0; ldsz = '0; ldreq = 1'b0; ldcache = 1'b1;
    fence = 1'b0; dcbusy = 1'b0; dcdbe = 1'b0;
    tick();
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_dcwrite", dcwrite, 0);
    check("rst_wberr", wberr, 0);
    check("rst_conflict", conflict, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single store: one-edge visibility, retire next edge.
    set_enq(1, 32'h100, 3'd7, 64'h1122334455667788);
    #1;
    check("t1_pre_dcwrite", dcwrite, 0);
    tick();
    enq = 1'b0;
    check("t1_count", count, 1);
    check("t1_dcwrite", dcwrite, 1);
    check("t1_dcpa", dcpa, 64'h100);
    check("t1_dcsz", dcsz, 7);
    check("t1_dcwdata", dcwdata, 64'h1122334455667788);
    tick();
    check("t1_count_after", count, 0);
    check("t1_dcwrite_after", dcwrite, 0);

    // phi2 low blocks state change.
    phi2 = 1'b0;
    set_enq(1, 32'h180, 3'd0, 64'h0);
    tick();
    check("phi2_gate_count", count, 0);
    enq = 1'b0;
    phi2 = 1'b1;

    // Fill to full, overflow drop, same-edge retire does not admit enqueue.
    dcbusy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_enq(1, 32'(k * 8), 3'd7, 64'(k + 1));
      tick();
      if (k == 3) check("t2_full_after4", full, 1);
    end
    enq = 1'b0;
    check("t2_count_after5", count, 4);
    check("t2_full", full, 1);
    dcbusy = 1'b0;
    set_enq(1, 32'h40, 3'd7, 64'hdead);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_order_pa%0d", k), dcpa, 64'(k * 8));
      check($sformatf("t2_order_data%0d", k), dcwdata, 64'(k + 1));
      tick();
      enq = 1'b0;
      if (k == 0) check("t2_count_fullretire", count, 3);
    end
    check("t2_drained", count, 0);
    check("t2_drained_dcwrite", dcwrite, 0);

    // Address overlap.
    dcbusy = 1'b1;
    set_enq(1, 32'h104, 3'd3, 64'h0);
    tick();
    enq = 1'b0;
    ldreq = 1'b1; ldcache = 1'b1;
    ldpa = 32'h106; ldsz = 3'd1; #1;
    check("t3_overlap", conflict, 1);
    ldpa = 32'h100; ldsz = 3'd3; #1;
    check("t3_below", conflict, 0);
    ldpa = 32'h108; ldsz = 3'd1; #1;
    check("t3_next_dword", conflict, 0);
    ldpa = 32'h107; ldsz = 3'd0; #1;
    check("t3_last_lane", conflict, 1);
    ldpa = 32'h1104; ldsz = 3'd3; #1;
    check("t3_upper_diff", conflict, 0);
    ldpa = 32'h106; ldsz = 3'd1; ldreq = 1'b0; #1;
    check("t3_noreq", conflict, 0);
    ldreq = 1'b1; ldpa = 32'h200; ldsz = 3'd7;
    set_enq(1, 32'h203, 3'd0, 64'h0); #1;
    check("t3_same_cycle_enq", conflict, 1);
    enq = 1'b0; #1;
    check("t3_no_enq", conflict, 0);

    // Uncached load and fence drain.
    ldcache = 1'b0; ldpa = 32'h300; ldsz = 3'd0; fence = 1'b1; #1;
    check("t4_uncached", conflict, 1);
    check("t4_fencebusy", fencebusy, 1);
    dcbusy = 1'b0;
    tick();
    check("t4_count0", count, 0);
    check("t4_uncached_clear", conflict, 0);
    check("t4_fence_clear", fencebusy, 0);
    set_enq(1, 32'h300, 3'd0, 64'h0); #1;
    check("t4_fence_enq", fencebusy, 1);
    check("t4_uncached_enq", conflict, 1);
    enq = 1'b0; fence = 1'b0; ldreq = 1'b0; ldcache = 1'b1;

    // Simultaneous enqueue/retire and bus error pulse.
    dcbusy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_enq(1, 32'h500 + 32'(k * 8), 3'd7, 64'h0);
      tick();
    end
    check("t5_count3", count, 3);
    set_enq(1, 32'h518, 3'd7, 64'h0);
    dcbusy = 1'b0; dcdbe = 1'b1;
    tick();
    enq = 1'b0; dcbusy = 1'b1; dcdbe = 1'b0;
    check("t5_count_same", count, 3);
    check("t5_wberr", wberr, 1);
    check("t5_head_advanced", dcpa, 64'h508);
    phi2 = 1'b0;
    tick();
    check("t5_wberr_hold", wberr, 1);
    phi2 = 1'b1;
    tick();
    check("t5_wberr_once", wberr, 0);
    check("t5_count_hold", count, 3);

    // Asynchronous reset between edges discards pending stores.
    dcbusy = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_dcwrite", dcwrite, 0);
    check("t6_count", count, 0);
    check("t6_full", full, 0);
    tick();
    reset = 1'b0;
    dcbusy = 1'b1;
    set_enq(1, 32'h600, 3'd7, 64'h0);
    tick();
    enq = 1'b0;
    check("t6_enq_count", count, 1);
    check("t6_enq_pa", dcpa, 64'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
